// File: rtl/key_step_counter.sv
// key_step_counter: synchronised, debounced UP/DOWN/CLEAR keys driving a
// CNT_W-bit up/down counter with wrap or saturate behaviour.
// Optional build macro KEY_STEP_AUTO_REPEAT_EN adds auto-repeat steps while a
// key is held in the long-press state; without it each press is one step.
module key_step_counter #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int CNT_W        = 4,
    parameter int SATURATE     = 0
) (
    input  logic             FPGA_CLK,
    input  logic             RESET_BUT,
    input  logic             key_up_n,
    input  logic             key_dn_n,
    input  logic             key_clr_n,
    output logic [CNT_W-1:0] count,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             long_press,
    output logic             at_max,
    output logic             at_min
);

    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int LONG_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_LONG  = 2'd2;

    // Key index: 0 = UP, 1 = DOWN, 2 = CLEAR (levels are active-low)
    logic [2:0]        raw_keys;
    logic [2:0]        sync_p0;
    logic [2:0]        sync_p1;
    logic [2:0]        deb_level;
    logic [DB_W-1:0]   db_cnt [3];
    logic [2:0]        pressed;

    logic [1:0]        key_state [2];
    logic [LONG_W-1:0] hold_cnt [2];
    logic [1:0]        step_req;

    logic              clr_prev;
    logic              clr_edge;

    assign raw_keys = {key_clr_n, key_dn_n, key_up_n};
    assign pressed  = ~deb_level;

    // Two-flop synchroniser per key; released (high) after reset
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= raw_keys;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: level follows the synchronised key only after it has differed for DEBOUNCE_CYC cycles
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            deb_level <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] != deb_level[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        deb_level[i] <= sync_p1[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // UP/DOWN key FSMs with a saturating hold counter
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            for (int k = 0; k < 2; k++) begin
                key_state[k] <= S_IDLE;
                hold_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!pressed[k]) begin
                    key_state[k] <= S_IDLE;
                    hold_cnt[k]  <= '0;
                end else begin
                    if (hold_cnt[k] != LONG_MAX) hold_cnt[k] <= hold_cnt[k] + 1'b1;
                    case (key_state[k])
                        S_IDLE:  key_state[k] <= S_PRESS;
                        S_PRESS: if (hold_cnt[k] == LONG_MAX) key_state[k] <= S_LONG;
                        S_LONG:  key_state[k] <= S_LONG;
                        default: key_state[k] <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef KEY_STEP_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYC - 1);

    logic [RPT_W-1:0] rpt_cnt [2];
    logic [1:0]       rep_tick;

    // Repeat timer: one tick every REPEAT_CYC cycles spent in LONG, first one REPEAT_CYC after entry
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            rep_tick <= '0;
            for (int k = 0; k < 2; k++) rpt_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rep_tick[k] <= 1'b0;
                if (key_state[k] == S_LONG && pressed[k]) begin
                    if (rpt_cnt[k] == RPT_MAX) begin
                        rpt_cnt[k]  <= '0;
                        rep_tick[k] <= 1'b1;
                    end else begin
                        rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                    end
                end else begin
                    rpt_cnt[k] <= '0;
                end
            end
        end
    end

    assign step_req[0] = pressed[0] & ((key_state[0] == S_IDLE) | rep_tick[0]);
    assign step_req[1] = pressed[1] & ((key_state[1] == S_IDLE) | rep_tick[1]);
`else
    logic repeat_unused;
    assign repeat_unused = (REPEAT_CYC > 0);

    assign step_req[0] = pressed[0] & (key_state[0] == S_IDLE);
    assign step_req[1] = pressed[1] & (key_state[1] == S_IDLE);
`endif

    // Remember the debounced CLEAR level so only its press edge clears the count
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) clr_prev <= 1'b0;
        else           clr_prev <= pressed[2];
    end

    assign clr_edge = pressed[2] & ~clr_prev;

    // Counter update: CLEAR, then UP+DOWN cancel, then single UP or DOWN step
    always_ff @(posedge FPGA_CLK) begin
        if (RESET_BUT) begin
            count    <= '0;
            up_pulse <= 1'b0;
            dn_pulse <= 1'b0;
        end else begin
            up_pulse <= 1'b0;
            dn_pulse <= 1'b0;
            if (clr_edge) begin
                count <= '0;
            end else if (step_req[0] && step_req[1]) begin
                count <= count;
            end else if (step_req[0]) begin
                if (!(SATURATE != 0 && count == CNT_MAX)) begin
                    count    <= count + 1'b1;
                    up_pulse <= 1'b1;
                end
            end else if (step_req[1]) begin
                if (!(SATURATE != 0 && count == '0)) begin
                    count    <= count - 1'b1;
                    dn_pulse <= 1'b1;
                end
            end
        end
    end

    assign long_press = (key_state[0] == S_LONG) || (key_state[1] == S_LONG);
    assign at_max     = (count == CNT_MAX);
    assign at_min     = (count == '0);

endmodule

// File: tb/tb_key_step_counter.sv
// Scoreboard bench for key_step_counter: a wrap-mode and a saturate-mode
// instance, each with its own keys. Stimulus queues expected pulses and
// status values; the monitor pops and compares them on the falling edge.
module tb_key_step_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b = 1'b0;
    logic [2:0] kw = 3'b111;   // wrap instance keys: bit0 UP, bit1 DOWN, bit2 CLEAR
    logic [2:0] ks = 3'b111;   // saturate instance keys

    logic [3:0] w_count, s_count;
    logic       w_up, w_dn, w_long, w_max, w_min;
    logic       s_up, s_dn, s_long, s_max, s_min;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_step_counter #(.DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .CNT_W(4), .SATURATE(0)) dut_w (
        .FPGA_CLK(clk), .RESET_BUT(rst_b),
        .key_up_n(kw[0]), .key_dn_n(kw[1]), .key_clr_n(kw[2]),
        .count(w_count), .up_pulse(w_up), .dn_pulse(w_dn),
        .long_press(w_long), .at_max(w_max), .at_min(w_min)
    );

    key_step_counter #(.DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .CNT_W(4), .SATURATE(1)) dut_s (
        .FPGA_CLK(clk), .RESET_BUT(rst_b),
        .key_up_n(ks[0]), .key_dn_n(ks[1]), .key_clr_n(ks[2]),
        .count(s_count), .up_pulse(s_up), .dn_pulse(s_dn),
        .long_press(s_long), .at_max(s_max), .at_min(s_min)
    );

    typedef struct { bit up; int cyc; logic [3:0] cnt; } pulse_t;
    typedef struct { bit sat; int field; int expv; } stat_t;

    pulse_t q_w[$];
    pulse_t q_s[$];
    stat_t  q_st[$];

    int n_chk  = 0;
    int n_fail = 0;

    localparam int F_COUNT = 0, F_UP = 1, F_DN = 2, F_LONG = 3, F_MAX = 4, F_MIN = 5,
                   F_QW = 6, F_QS = 7;

    function automatic int obs(bit sat, int f);
        case (f)
            F_COUNT: return sat ? int'(s_count) : int'(w_count);
            F_UP:    return sat ? int'(s_up)    : int'(w_up);
            F_DN:    return sat ? int'(s_dn)    : int'(w_dn);
            F_LONG:  return sat ? int'(s_long)  : int'(w_long);
            F_MAX:   return sat ? int'(s_max)   : int'(w_max);
            F_MIN:   return sat ? int'(s_min)   : int'(w_min);
            F_QW:    return q_w.size();
            default: return q_s.size();
        endcase
    endfunction

    function automatic string fname(int f);
        case (f)
            F_COUNT: return "count";
            F_UP:    return "up_pulse";
            F_DN:    return "dn_pulse";
            F_LONG:  return "long_press";
            F_MAX:   return "at_max";
            F_MIN:   return "at_min";
            F_QW:    return "wrap_pending_pulses";
            default: return "sat_pending_pulses";
        endcase
    endfunction

    // Monitor: pulses are matched against the pulse queues, then queued status checks are evaluated
    always @(negedge clk) begin
        pulse_t e;
        stat_t  s;
        int     got;
        if (w_up || w_dn) begin
            n_chk++;
            if (q_w.size() == 0) begin
                n_fail++;
                $display("FAIL wrap_pulse cyc=%0d: got up=%0b dn=%0b count=%0d, required no pulse", cyc, w_up, w_dn, w_count);
            end else begin
                e = q_w.pop_front();
                if (w_up !== e.up || w_dn !== !e.up || cyc != e.cyc || w_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL wrap_pulse: got up=%0b dn=%0b cyc=%0d count=%0d, required up=%0b cyc=%0d count=%0d",
                             w_up, w_dn, cyc, w_count, e.up, e.cyc, e.cnt);
                end
            end
        end
        if (s_up || s_dn) begin
            n_chk++;
            if (q_s.size() == 0) begin
                n_fail++;
                $display("FAIL sat_pulse cyc=%0d: got up=%0b dn=%0b count=%0d, required no pulse", cyc, s_up, s_dn, s_count);
            end else begin
                e = q_s.pop_front();
                if (s_up !== e.up || s_dn !== !e.up || cyc != e.cyc || s_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL sat_pulse: got up=%0b dn=%0b cyc=%0d count=%0d, required up=%0b cyc=%0d count=%0d",
                             s_up, s_dn, cyc, s_count, e.up, e.cyc, e.cnt);
                end
            end
        end
        while (q_st.size() > 0) begin
            s = q_st.pop_front();
            got = obs(s.sat, s.field);
            n_chk++;
            if (got != s.expv) begin
                n_fail++;
                $display("FAIL %s_%s cyc=%0d: got %0d, required %0d", s.sat ? "sat" : "wrap", fname(s.field), cyc, got, s.expv);
            end
        end
    end

    task automatic expect_stat(input bit sat, input int f, input int v);
        stat_t s;
        s.sat = sat; s.field = f; s.expv = v;
        q_st.push_back(s);
    endtask

    task automatic push_pulse(input bit sat, input bit up, input int at, input logic [3:0] v);
        pulse_t p;
        p.up = up; p.cyc = at; p.cnt = v;
        if (sat) q_s.push_back(p);
        else     q_w.push_back(p);
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 2; i++) begin
            expect_stat(i[0], F_COUNT, 0);
            expect_stat(i[0], F_UP, 0);
            expect_stat(i[0], F_DN, 0);
            expect_stat(i[0], F_LONG, 0);
            expect_stat(i[0], F_MAX, 0);
            expect_stat(i[0], F_MIN, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        chk_reset();
    endtask

    // Press keys in mask for hold cycles; a step pulse lands 7 edges after the press
    task automatic tap(input bit sat, input logic [2:0] mask, input int hold,
                       input bit exp_pulse, input bit exp_up, input logic [3:0] exp_cnt);
        @(posedge clk); #1;
        if (sat) ks = ks & ~mask;
        else     kw = kw & ~mask;
        if (exp_pulse) push_pulse(sat, exp_up, cyc + 7, exp_cnt);
        repeat (hold) @(posedge clk);
        #1;
        if (sat) ks = ks | mask;
        else     kw = kw | mask;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single UP tap
        tap(1'b0, 3'b001, 10, 1'b1, 1'b1, 4'd1);
        expect_stat(1'b0, F_COUNT, 1);

        // Glitches shorter than the debounce window
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            kw[0] = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            kw[0] = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        expect_stat(1'b0, F_COUNT, 0);

        // Wrap at both ends
        tap(1'b0, 3'b010, 10, 1'b1, 1'b0, 4'd15);
        expect_stat(1'b0, F_MAX, 1);
        tap(1'b0, 3'b001, 10, 1'b1, 1'b1, 4'd0);
        expect_stat(1'b0, F_MIN, 1);

        // UP and DOWN together cancel
        tap(1'b0, 3'b011, 10, 1'b0, 1'b0, 4'd0);
        expect_stat(1'b0, F_COUNT, 0);

        // Walk down to 9, then CLEAR
        for (int j = 1; j <= 7; j++) tap(1'b0, 3'b010, 10, 1'b1, 1'b0, 4'(16 - j));
        expect_stat(1'b0, F_COUNT, 9);
        tap(1'b0, 3'b100, 10, 1'b0, 1'b0, 4'd0);
        expect_stat(1'b0, F_COUNT, 0);
        expect_stat(1'b0, F_MIN, 1);

        // Long DOWN hold from 8
        for (int j = 1; j <= 8; j++) tap(1'b0, 3'b001, 10, 1'b1, 1'b1, 4'(j));
        expect_stat(1'b0, F_COUNT, 8);
        @(posedge clk); #1;
        kw[1] = 1'b0;
        n0 = cyc;
        push_pulse(1'b0, 1'b0, n0 + 7, 4'd7);
`ifdef KEY_STEP_AUTO_REPEAT_EN
        for (int j = 1; j <= 7; j++) push_pulse(1'b0, 1'b0, n0 + 27 + 5 * j, 4'(7 - j));
`endif
        repeat (25) @(posedge clk);
        #1;
        expect_stat(1'b0, F_LONG, 0);
        @(posedge clk); #1;
        expect_stat(1'b0, F_LONG, 1);
        repeat (34) @(posedge clk);
        #1;
        kw[1] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        expect_stat(1'b0, F_LONG, 0);
`ifdef KEY_STEP_AUTO_REPEAT_EN
        expect_stat(1'b0, F_COUNT, 0);
`else
        expect_stat(1'b0, F_COUNT, 7);
`endif

        // Reset in the middle of an UP hold
        do_reset();
        @(posedge clk); #1;
        kw[0] = 1'b0;
        push_pulse(1'b0, 1'b1, cyc + 7, 4'd1);
        repeat (12) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        chk_reset();
        push_pulse(1'b0, 1'b1, cyc + 7, 4'd1);
        repeat (12) @(posedge clk);
        #1;
        kw[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        expect_stat(1'b0, F_COUNT, 1);

        // Saturate instance: DOWN at 0 dropped, climb to 15, UP at 15 dropped
        do_reset();
        tap(1'b1, 3'b010, 10, 1'b0, 1'b0, 4'd0);
        expect_stat(1'b1, F_COUNT, 0);
        for (int j = 1; j <= 15; j++) tap(1'b1, 3'b001, 10, 1'b1, 1'b1, 4'(j));
        expect_stat(1'b1, F_MAX, 1);
        tap(1'b1, 3'b001, 10, 1'b0, 1'b0, 4'd0);
        expect_stat(1'b1, F_COUNT, 15);
        expect_stat(1'b1, F_UP, 0);

        // Every queued pulse must have been seen
        repeat (5) @(posedge clk);
        #1;
        expect_stat(1'b0, F_QW, 0);
        expect_stat(1'b0, F_QS, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
